// File: rtl/msg_frame_ctrl.sv
// Frames an AXI-Stream path into messages of a configured beat count, marks the last beat,
// and on abort drains the remainder of the message upstream without forwarding it.
module msg_frame_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_COUNT_BITS = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [NUM_COUNT_BITS-1:0] cfg_length_i,
    input  logic                      abort_i,
    input  logic [DATA_WIDTH-1:0]     s_tdata_i,
    input  logic                      s_tvalid_i,
    output logic                      s_tready_o,
    output logic [DATA_WIDTH-1:0]     m_tdata_o,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic                      m_tlast_o,
    output logic [NUM_COUNT_BITS-1:0] beat_count_o,
    output logic [NUM_COUNT_BITS-1:0] msg_total_o,
    output logic                      msg_done_o,
    output logic                      msg_aborted_o,
    output logic                      err_zero_len_o
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam logic [NUM_COUNT_BITS-1:0] ONE = NUM_COUNT_BITS'(1);

    state_t                    state_q;
    logic [NUM_COUNT_BITS-1:0] len_q;
    logic [NUM_COUNT_BITS-1:0] beat_q;
    logic [NUM_COUNT_BITS-1:0] total_q;
    logic                      done_q;
    logic                      aborted_q;
    logic                      zerr_q;
    logic                      xfer;
    logic                      last_beat;

    assign last_beat = (beat_q == len_q - ONE);

    // No buffering: handshake signals are combinational so a beat costs zero latency.
    always_comb begin
        s_tready_o = 1'b0;
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        case (state_q)
            STREAM: begin
                m_tvalid_o = s_tvalid_i && !abort_i;
                s_tready_o = m_tready_i && !abort_i;
                m_tlast_o  = last_beat;
            end
            FLUSH:   s_tready_o = 1'b1;
            default: ;
        endcase
    end

    assign xfer           = s_tvalid_i && s_tready_o;
    assign m_tdata_o      = s_tdata_i;
    assign cfg_ready_o    = (state_q == IDLE);
    assign beat_count_o   = beat_q;
    assign msg_total_o    = total_q;
    assign msg_done_o     = done_q;
    assign msg_aborted_o  = aborted_q;
    assign err_zero_len_o = zerr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            beat_q    <= '0;
            total_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            zerr_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            zerr_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        if (cfg_length_i != '0) begin
                            len_q   <= cfg_length_i;
                            beat_q  <= '0;
                            state_q <= STREAM;
                        end else begin
                            zerr_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // Abort wins over a coincident beat; the equal-count branch is defensive only.
                    if (abort_i) begin
                        if (beat_q == len_q) begin
                            aborted_q <= 1'b1;
                            beat_q    <= '0;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end else if (xfer) begin
                        if (last_beat) begin
                            done_q  <= 1'b1;
                            total_q <= total_q + ONE;
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q + ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (xfer) begin
                        if (beat_q + ONE == len_q) begin
                            aborted_q <= 1'b1;
                            beat_q    <= '0;
                            state_q   <= IDLE;
                        end else begin
                            beat_q <= beat_q + ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/msg_frame_ctrl.md
# msg_frame_ctrl

Sequencer for a single AXI-Stream message path. It accepts a message length through a config handshake, then passes exactly that many beats from slave to master and marks the final beat with `m_tlast`. Internally it tracks the beat count, and it supports an abort that flushes the rest of the message. It sits upstream of the message-length counter and gives it a framed stream with a known length.

## Interface
- `DATA_WIDTH`, 32, stream data width.
- `NUM_COUNT_BITS`, 16, width of message length and beat counter.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  high only in IDLE.
- `cfg_length`  in  NUM_COUNT_BITS  beats in next message.
- `abort`  in  1  abort request, level-sampled.
- `s_tdata`  in  DATA_WIDTH  upstream data.
- `s_tvalid`  in  1  upstream valid.
- `s_tready`  out  1  upstream ready.
- `m_tdata`  out  DATA_WIDTH  equals `s_tdata`, passed through combinationally.
- `m_tvalid`  out  1  downstream valid.
- `m_tready`  in  1  downstream ready.
- `m_tlast`  out  1  final beat marker.
- `beat_count`  out  NUM_COUNT_BITS  beats consumed in the current message.
- `msg_total`  out  NUM_COUNT_BITS  completed (non-aborted) messages; wraps modulo 2^NUM_COUNT_BITS.
- `msg_done`  out  1  one-cycle pulse when a message completes.
- `msg_aborted`  out  1  one-cycle pulse when a flush completes.
- `err_zero_len`  out  1  one-cycle pulse when a zero-length config is rejected.

## Operation
- **FSM states:** IDLE, STREAM, FLUSH.
- **Reset:**
  - State is IDLE.
  - `len_r`, `beat_count` and `msg_total` are 0.
  - All pulses are 0.
  - `s_tready`, `m_tvalid` and `m_tlast` are 0.
  - `cfg_ready` is 1 (it follows the state).
- **IDLE:**
  - On `cfg_valid && cfg_ready` with `cfg_length != 0`: latch `len_r`, clear `beat_count`, go to STREAM.
  - On `cfg_length == 0`: pulse `err_zero_len` next cycle and stay in IDLE.
  - `abort` is ignored.
- **STREAM:**
  - `m_tvalid = s_tvalid && !abort`.
  - `s_tready = m_tready && !abort`.
  - `m_tlast = (beat_count == len_r - 1)`.
  - The subtraction is NUM_COUNT_BITS wide and cannot underflow because `len_r >= 1`.
  - Each transfer (`s_tvalid && s_tready`) increments `beat_count`.
  - A transfer with `m_tlast` high moves to IDLE and pulses `msg_done`.
  - In that same cycle, `msg_total` increments and `beat_count` returns to 0.
- **Abort in STREAM:**
  - `abort` has priority. No beat transfers in the cycle `abort` is high.
  - Next state is FLUSH, or IDLE with a `msg_aborted` pulse if `beat_count == len_r`. That case cannot occur, so it is included only for safety.
- **FLUSH:**
  - `s_tready = 1`, `m_tvalid = 0`, `m_tlast = 0`.
  - Each accepted upstream beat is discarded and increments `beat_count`.
  - The beat that makes `beat_count == len_r` moves to IDLE. It also pulses `msg_aborted` and clears `beat_count`.
  - `msg_total` is unchanged.
  - `abort` is ignored.
- **Config outside IDLE:** `cfg_valid` in STREAM or FLUSH is not accepted, because `cfg_ready = 0`. The requester must hold `cfg_valid` until accepted.
- **Maximum length:** `cfg_length = 2^NUM_COUNT_BITS - 1` is legal. `beat_count` never wraps within a message.

## Timing
- **Config accept:** accepted at edge N, the state is STREAM in cycle N+1. `s_tready` may assert in cycle N+1, giving zero bubble after config.
- **Data path:** fully combinational, 0-cycle latency from s to m. There is no buffering, so `s_tready` depends combinationally on `m_tready`.
- **Message done:** for a last-beat transfer in cycle M, `msg_done` is high in M+1 and `cfg_ready` is high in M+1. The next config can be accepted in M+1.
- **Back-to-back messages:** minimum gap between one message's last beat and the next message's first beat is 2 cycles: config in M+1, first beat in M+2.
- **Status pulses:** all pulses are registered, exactly one cycle wide.
- **Reset mid-message:** the frame is dropped silently with no pulse. The block is in IDLE the cycle after `rst` deasserts.

## Test plan
- **Normal frame:** reset, config length 4, `m_tready = 1`, 4 beats D0–D3.
  - Expect `m_tlast` only on D3.
  - Expect `msg_done` 1 cycle later, `msg_total = 1`, `cfg_ready = 1`.
- **Backpressure:** length 5 with `m_tready` toggling 1,0,0,1…
  - Expect `s_tready` to mirror `m_tready` and `beat_count` to hold on stall cycles.
  - Expect all 5 beats in order, `m_tlast` on the 5th.
- **Length-1 and back-to-back:** length 1, then length 2 configured in the `msg_done` cycle.
  - Expect `m_tlast` on the first beat.
  - Expect the second message to accept cfg in M+1 and its first beat in M+2.
  - Expect `msg_total = 2`.
- **Zero length:** config with `cfg_length = 0`.
  - Expect `err_zero_len` pulsed once, state stays IDLE, no `s_tready`.
  - A subsequent length-3 config works normally.
- **Abort:** length 5, 2 beats transferred, then `abort` coincident with `s_tvalid`.
  - Expect no transfer that cycle, then FLUSH with `s_tready = 1` and `m_tvalid = 0`.
  - Expect 3 beats discarded, `msg_aborted` pulse, `msg_total` unchanged.
- **Reset mid-stream:** `rst` asserted after 2 of 4 beats.
  - Expect all outputs at reset values immediately, `cfg_ready = 1` after release.
  - Expect no `msg_done` or `msg_aborted` pulse.
